sw_alloc_2to1: RTL

Packet-granular, credit-aware round-robin switch allocator that drives the select input of the 2:1 output mux in the router datapath. It arbitrates between the two input ports on HEAD flits, holds the mux select for the winning port until that packet's TAIL passes, and tracks per-VC downstream buffer credits. The block stalls the owning input whenever the downstream VC has no free slot. It sits directly upstream of the output mux and sees the same `ivalid_*`/`ivch_*` and flit-type bits the mux receives.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/sw_alloc_credit.sv | 42 ++++
 rtl/sw_alloc_2to1.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit-type, allocator state and credit-width definitions
package noc_pkg;

    localparam logic [1:0] FLIT_NONE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;
    localparam logic [1:0] FLIT_DATA = 2'b11;

    localparam int CRED_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } alloc_state_t;

    function automatic logic [1:0] port_sel(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sw_alloc_credit.sv
// rtl/sw_alloc_credit.sv - one saturating downstream credit counter for a single VC
module sw_alloc_credit
    import noc_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_consume,
    input  logic              i_return,
    output logic [CRED_W-1:0] o_count,
    output logic              o_avail,
    output logic              o_full
);

    localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(CREDITS);
    localparam logic [CRED_W-1:0] ONE      = CRED_W'(1);

    logic [CRED_W-1:0] r_count;

    // Simultaneous consume and return cancel out, so that case leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= MAX_CRED;
        end else begin
            case ({i_consume, i_return})
                2'b10: begin
                    if (r_count != '0) r_count <= r_count - ONE;
                end
                2'b01: begin
                    if (r_count != MAX_CRED) r_count <= r_count + ONE;
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_avail = (r_count != '0);
    assign o_full  = (r_count == MAX_CRED);

endmodule

// File: rtl/sw_alloc_2to1.sv
// rtl/sw_alloc_2to1.sv - packet-granular credit-aware 2:1 round-robin switch allocator
// Optional protocol checker with sticky oerr output: SW_ALLOC_PROTO_CHK_EN.
module sw_alloc_2to1
    import noc_pkg::*;
#(
    parameter int VCH     = 2,
    parameter int CREDITS = 4,
    localparam int VW     = (VCH > 1) ? $clog2(VCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ivalid_0,
    input  logic                  ivalid_1,
    input  logic [1:0]            itype_0,
    input  logic [1:0]            itype_1,
    input  logic [VW-1:0]         ivch_0,
    input  logic [VW-1:0]         ivch_1,
    input  logic                  icredit_valid,
    input  logic [VW-1:0]         icredit_vch,
    output logic [1:0]            sel,
    output logic                  ogrant_0,
    output logic                  ogrant_1,
    output logic                  oen,
    output logic [VCH*CRED_W-1:0] ocredit
`ifdef SW_ALLOC_PROTO_CHK_EN
   ,output logic                  oerr
`endif
);

    alloc_state_t r_state;
    logic         r_prio;

    logic [VCH-1:0] w_avail;
    logic [VCH-1:0] w_full;
    logic [VCH-1:0] w_consume_vec;
    logic [VCH-1:0] w_return_vec;
    logic           w_req0;
    logic           w_req1;
    logic [VW-1:0]  w_cons_vch;

    for (genvar v = 0; v < VCH; v++) begin : g_vc
        assign w_consume_vec[v] = oen && (w_cons_vch == VW'(v));
        assign w_return_vec[v]  = icredit_valid && (icredit_vch == VW'(v));

        sw_alloc_credit #(
            .CREDITS (CREDITS)
        ) u_credit (
            .clk       (clk),
            .rst       (rst),
            .i_consume (w_consume_vec[v]),
            .i_return  (w_return_vec[v]),
            .o_count   (ocredit[v*CRED_W +: CRED_W]),
            .o_avail   (w_avail[v]),
            .o_full    (w_full[v])
        );
    end

    // Zero-cycle arbitration: grants come straight from state, credits and live inputs.
    always_comb begin
        sel      = 2'b00;
        ogrant_0 = 1'b0;
        ogrant_1 = 1'b0;
        w_req0   = ivalid_0 && (itype_0 == FLIT_HEAD) && w_avail[ivch_0];
        w_req1   = ivalid_1 && (itype_1 == FLIT_HEAD) && w_avail[ivch_1];
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && (!w_req1 || !r_prio)) begin
                    ogrant_0 = 1'b1;
                    sel      = port_sel(1'b0);
                end else if (w_req1) begin
                    ogrant_1 = 1'b1;
                    sel      = port_sel(1'b1);
                end
            end
            ST_LOCK0: begin
                sel      = port_sel(1'b0);
                ogrant_0 = ivalid_0 && w_avail[ivch_0];
            end
            ST_LOCK1: begin
                sel      = port_sel(1'b1);
                ogrant_1 = ivalid_1 && w_avail[ivch_1];
            end
            default: ;
        endcase
    end

    assign oen        = ogrant_0 | ogrant_1;
    assign w_cons_vch = ogrant_1 ? ivch_1 : ivch_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ogrant_0)      r_state <= ST_LOCK0;
                    else if (ogrant_1) r_state <= ST_LOCK1;
                end
                ST_LOCK0: begin
                    if (ogrant_0 && (itype_0 == FLIT_TAIL)) begin
                        r_state <= ST_IDLE;
                        r_prio  <= 1'b1;
                    end
                end
                ST_LOCK1: begin
                    if (ogrant_1 && (itype_1 == FLIT_TAIL)) begin
                        r_state <= ST_IDLE;
                        r_prio  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SW_ALLOC_PROTO_CHK_EN
    logic [VW-1:0] r_head_vch;
    logic          r_err;
    logic          w_err_set;

    // The owner's VC is latched at HEAD so later flits of the packet can be held to it.
    assign w_err_set =
        (icredit_valid && w_full[icredit_vch]) ||
        ((r_state == ST_LOCK0) && ogrant_0 && (itype_0 == FLIT_HEAD)) ||
        ((r_state == ST_LOCK1) && ogrant_1 && (itype_1 == FLIT_HEAD)) ||
        ((r_state == ST_LOCK0) && ivalid_0 && (ivch_0 != r_head_vch)) ||
        ((r_state == ST_LOCK1) && ivalid_1 && (ivch_1 != r_head_vch));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_vch <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && oen) r_head_vch <= w_cons_vch;
            if (w_err_set)                   r_err      <= 1'b1;
        end
    end

    assign oerr = r_err;
`else
    logic w_unused_full;
    assign w_unused_full = ^w_full;
`endif

endmodule
